// File: rtl/sigma_delta_feeder.sv
// sigma_delta_feeder: buffers PCM samples in a small FIFO and feeds the
// sigma-delta modulator one sample per programmable hold period, with
// prefill, underrun signalling and flush-on-stop.
module sigma_delta_feeder #(
    parameter int unsigned VALUE_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned RATE_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          run,
    input  logic [RATE_WIDTH-1:0]         rate,
    input  logic [VALUE_WIDTH-1:0]        s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic [VALUE_WIDTH-1:0]        value,
    output logic                          enable,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [VALUE_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [RATE_WIDTH-1:0]  cnt;

    logic [VALUE_WIDTH-1:0] value_nxt;
    logic                   enable_nxt;
    logic                   underrun_nxt;
    logic [RATE_WIDTH-1:0]  cnt_nxt;
    logic                   push;
    logic                   pop;
    logic                   flush;
    logic [RATE_WIDTH-1:0]  reload;
    logic [VALUE_WIDTH-1:0] head;
    logic [LVL_W-1:0]       level_nxt;

    // Ready is a pure function of occupancy: a full FIFO never takes a push,
    // even on a cycle that pops.
    assign s_ready = (level != FULL_LVL);
    assign push    = s_valid && s_ready;
    assign head    = mem[rd_ptr];

    // Hold period minus one, with rate 0 treated as 1.
    assign reload  = (rate == '0) ? '0 : rate - RATE_WIDTH'(1);

    // Occupancy update; a flush overrides any push or pop in the same cycle.
    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else begin
            level_nxt = level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Next-state, sample output, hold counter and FIFO pop control.
    always_comb begin
        state_nxt    = state;
        value_nxt    = value;
        enable_nxt   = enable;
        underrun_nxt = 1'b0;
        cnt_nxt      = cnt;
        pop          = 1'b0;
        flush        = 1'b0;

        case (state)
            ST_IDLE: begin
                enable_nxt = 1'b0;
                value_nxt  = '0;
                if (run) begin
                    state_nxt = ST_FILL;
                end
            end

            ST_FILL: begin
                enable_nxt = 1'b0;
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else if (level == FULL_LVL) begin
                    state_nxt  = ST_RUN;
                    pop        = 1'b1;
                    value_nxt  = head;
                    enable_nxt = 1'b1;
                    cnt_nxt    = reload;
                end
            end

            ST_RUN: begin
                if (!run) begin
                    state_nxt  = ST_IDLE;
                    enable_nxt = 1'b0;
                    value_nxt  = '0;
                    cnt_nxt    = '0;
                    flush      = 1'b1;
                end else if (cnt != '0) begin
                    cnt_nxt = cnt - RATE_WIDTH'(1);
                end else if (level != '0) begin
                    pop       = 1'b1;
                    value_nxt = head;
                    cnt_nxt   = reload;
                end else begin
                    // Sample due but nothing buffered: hold value, retry next cycle.
                    underrun_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt  = ST_IDLE;
                enable_nxt = 1'b0;
                value_nxt  = '0;
                cnt_nxt    = '0;
                flush      = 1'b1;
            end
        endcase
    end

    // State, outputs, counter, pointers and occupancy registers.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            value    <= '0;
            enable   <= 1'b0;
            underrun <= 1'b0;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
        end else begin
            state    <= state_nxt;
            value    <= value_nxt;
            enable   <= enable_nxt;
            underrun <= underrun_nxt;
            cnt      <= cnt_nxt;
            level    <= level_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Sample storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

endmodule
